cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 32-bit ripple-of-4-bit-CLA adder.
- Operand width is split into STAGES slices. Each slice is built from GROUP-bit lookahead groups with group-level carry chaining.
- The carry between slices is registered and the operands are skewed, so throughput is one operation per clock at any width.
- valid/ready handshake with backpressure. Used in the datapath wherever a 32/64-bit add would otherwise limit timing.

Parameters:
- WIDTH, 32, operand/result width. Must be a multiple of GROUP*STAGES.
- GROUP, 4, bits per lookahead group; the lookahead cell generates G/P and internal carries.
- STAGES, 2, pipeline depth and number of slices. Slice width SW = WIDTH/STAGES. STAGES >= 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- c_in  in  1  carry-in (add) / borrow-in (sub)
- sub_in  in  1  0 = add, 1 = subtract
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum_o  out  WIDTH  result
- c_o  out  1  raw carry out of MSB (sub: 1 = no borrow)
- ovf_o  out  1  signed overflow

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - out_valid=0, sum_o=0, c_o=0, ovf_o=0.
  - All stage valid bits, partial sums, carries and skew registers cleared.
  - in_ready=1 once rst deasserts.
- Operand conditioning at accept:
  - Effective B = b_in XOR {WIDTH{sub_in}}.
  - Effective carry-in = c_in XOR sub_in.
  - sub=1 therefore computes a_in - b_in - c_in (mod 2^WIDTH).
- Stage k (0..STAGES-1):
  - Adds slice k of A and effective B using SW/GROUP lookahead groups.
  - Group carries are chained combinationally within the slice; carry-in is the registered carry-out of stage k-1 (stage 0: effective carry-in).
  - Result slice is registered. Upper, not-yet-added operand slices are carried forward in skew registers.
  - Lower result slices are carried forward so the full sum_o aligns at the last stage.
- Flags:
  - c_o = carry out of bit WIDTH-1.
  - ovf_o = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Both are registered with the final stage.
- Latency: accept at edge N → out_valid=1 after edge N+STAGES-1 (visible the cycle after the last register). STAGES=1 gives a registered output one cycle after accept.
- Throughput: one beat/clock while out_ready=1.
- Handshake and stall:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - Beat accepted when in_valid && in_ready. Result consumed when out_valid && out_ready.
  - en=0 freezes every stage register, including bubbles. Bubbles are not compressed.
  - While stalled: sum_o/c_o/ovf_o and out_valid hold stable.
  - in_ready is combinational from out_ready (documented; no path from in_valid to in_ready).
- Stage valid bits: stage 0 loads in_valid when en; stage k loads stage k-1's valid when en. Invalid beats still shift but never raise out_valid.
- Simultaneous accept and consume with a full pipe: allowed. Pipe advances, no loss or duplication.
- Wrap-around: results are mod 2^WIDTH. 0xFFFFFFFF+1 → sum 0, c_o=1.
- Reset mid-operation: all in-flight beats are discarded, none emitted after reset release.
- sub_in and c_in are sampled only on the accepting edge; per-beat mode mixing is supported.

Test Plan:
- (WIDTH=32, STAGES=2) Add: a=0x0000_FFFF, b=0x0000_0001, c_in=0 → 2 cycles later sum=0x0001_0000, c_o=0, ovf=0. Checks the inter-slice carry across bit 15/16.
- Wrap: a=0xFFFF_FFFF, b=0x0000_0000, c_in=1 → sum=0x0000_0000, c_o=1, ovf=0. Signed overflow: a=0x7FFF_FFFF, b=1 → sum=0x8000_0000, c_o=0, ovf=1.
- Subtract: sub=1, a=5, b=7, c_in=0 → sum=0xFFFF_FFFE, c_o=0 (borrow), ovf=0. Then a=0x8000_0000, b=1 → sum=0x7FFF_FFFF, ovf=1.
- Streaming: 100 back-to-back random beats with out_ready=1 → results in order, one per cycle after 2-cycle latency, and every result matches the reference model (a±b±c mod 2^32).
- Backpressure: stream with out_ready randomly low 50% → no drops or duplicates. While out_valid && !out_ready, outputs are stable and in_ready=0.
- Reset mid-flight: assert rst with 2 beats in flight → out_valid=0 immediately. After release, no stale result appears and the next beat computes correctly. Repeat with WIDTH=64, GROUP=4, STAGES=4 (latency 4).

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
//
// The operand width is split into STAGES slices of SW = WIDTH/STAGES bits. Each slice is
// summed by GROUP-bit lookahead groups whose group carries chain combinationally inside
// the slice. The slice carry-out is registered and handed to the next stage. Upper operand
// slices that are not yet added travel forward in skew registers. Lower result slices
// travel forward too, so the whole sum lines up at the last stage. The result is one beat
// per clock at any width.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready is combinational from out_ready)
//   a_in, b_in            operands
//   c_in, sub_in          carry/borrow in; 0 = add, 1 = subtract
//   out_valid / out_ready result handshake
//   sum_o, c_o, ovf_o     result, raw MSB carry-out (sub: 1 = no borrow), signed overflow
module cla_pipe_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
  output logic             ovf_o
);

  localparam int unsigned SW = WIDTH / STAGES;
  localparam int          NumGroups = int'(SW / GROUP);
  localparam int          GroupW    = int'(GROUP);

  // One lookahead group. Every carry is a flat sum-of-products of g/p and the group carry-in.
  // Returns {carry_out, sum}.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             ci);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             term;
    g = a & b;
    p = a ^ b;
    c = '0;
    for (int i = 0; i <= GroupW; i++) begin
      term = ci;
      for (int m = 0; m < i; m++) term = term & p[m];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  // One slice: the lookahead groups chained on their group carry-outs. Returns {carry_out, sum}.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b,
                                            input logic          ci);
    logic [SW-1:0]  s;
    logic           c;
    logic [GROUP:0] r;
    s = '0;
    c = ci;
    for (int n = 0; n < NumGroups; n++) begin
      r = cla_group(a[n*GroupW +: GROUP], b[n*GroupW +: GROUP], c);
      s[n*GroupW +: GROUP] = r[GROUP-1:0];
      c = r[GROUP];
    end
    return {c, s};
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             ovf_q;

  // One global enable. A stalled output freezes every stage, bubbles included.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = b_in ^ {WIDTH{sub_in}};
  assign c_eff    = c_in ^ sub_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo = k * SW;

    logic [WIDTH-1:Lo]   a_up;
    logic [WIDTH-1:Lo]   b_up;
    logic                ci;
    logic                vi;
    logic [Lo+SW-1:0]    sum_d;
    logic [SW:0]         res;
    logic                valid_q;
    logic                carry_q;
    logic [Lo+SW-1:0]    sum_q;

    if (k == 0) begin : g_src
      assign a_up  = a_in;
      assign b_up  = b_eff;
      assign ci    = c_eff;
      assign vi    = in_valid;
      assign sum_d = res[SW-1:0];
    end else begin : g_src
      assign a_up  = g_stage[k-1].g_skew.a_q;
      assign b_up  = g_stage[k-1].g_skew.b_q;
      assign ci    = g_stage[k-1].carry_q;
      assign vi    = g_stage[k-1].valid_q;
      assign sum_d = {res[SW-1:0], g_stage[k-1].sum_q};
    end

    assign res = cla_slice(a_up[Lo +: SW], b_up[Lo +: SW], ci);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (en) begin
        valid_q <= vi;
        carry_q <= res[SW];
        sum_q   <= sum_d;
      end
    end

    // Operand bits above this slice, not yet added.
    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:Lo+SW] a_q;
      logic [WIDTH-1:Lo+SW] b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_up[WIDTH-1:Lo+SW];
          b_q <= b_up[WIDTH-1:Lo+SW];
        end
      end
    end else begin : g_last
      // The carry into the MSB is recovered from a ^ b ^ sum at that bit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= a_up[WIDTH-1] ^ b_up[WIDTH-1] ^ res[SW-1] ^ res[SW];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum_o     = g_stage[STAGES-1].sum_q;
  assign c_o       = g_stage[STAGES-1].carry_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: a 32-bit/2-stage instance and a 64-bit/4-stage instance
// sharing clock and reset. Results are checked against an arithmetic reference model.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit, 2-stage instance
  logic        in_valid, in_ready, c_in, sub_in, out_valid, out_ready, c_o, ovf_o;
  logic [31:0] a_in, b_in, sum_o;
  // 64-bit, 4-stage instance
  logic        w_in_valid, w_in_ready, w_c_in, w_sub_in, w_out_valid, w_out_ready, w_c_o, w_ovf_o;
  logic [63:0] w_a_in, w_b_in, w_sum_o;

  int checks = 0;
  int fails  = 0;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .c_in(c_in), .sub_in(sub_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum_o(sum_o), .c_o(c_o), .ovf_o(ovf_o)
  );

  cla_pipe_adder #(.WIDTH(64), .GROUP(4), .STAGES(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .a_in(w_a_in),
    .b_in(w_b_in), .c_in(w_c_in), .sub_in(w_sub_in), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .sum_o(w_sum_o), .c_o(w_c_o), .ovf_o(w_ovf_o)
  );

  // Reference: {carry_out, signed_overflow, sum} for a w-bit add/sub.
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic c, input logic sub);
    logic [63:0] mask, am, be, sum;
    logic [64:0] full;
    logic        cout, ovf;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    be   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, be} + {64'd0, c ^ sub};
    sum  = full[63:0] & mask;
    cout = full[w];
    ovf  = (am[w-1] == be[w-1]) && (sum[w-1] != am[w-1]);
    return {cout, ovf, sum};
  endfunction

  task automatic send_recv32(input logic [31:0] a, input logic [31:0] b, input logic c,
                             input logic sub, output logic [31:0] s, output logic co,
                             output logic ov, output int lat);
    @(negedge clk);
    a_in = a; b_in = b; c_in = c; sub_in = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = sum_o; co = c_o; ov = ovf_o;
  endtask

  task automatic send_recv64(input logic [63:0] a, input logic [63:0] b, input logic c,
                             input logic sub, output logic [63:0] s, output logic co,
                             output logic ov, output int lat);
    @(negedge clk);
    w_a_in = a; w_b_in = b; w_c_in = c; w_sub_in = sub; w_in_valid = 1'b1; w_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w_in_valid = 1'b0;
    lat = 1;
    while (!w_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s = w_sum_o; co = w_c_o; ov = w_ovf_o;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({out_valid, c_o, ovf_o, sum_o} !== 35'd0) begin
      fails++;
      $display("FAIL reset32: got valid=%b c=%b ovf=%b sum=%h, expected all zero",
               out_valid, c_o, ovf_o, sum_o);
    end
    checks++;
    if ({w_out_valid, w_c_o, w_ovf_o, w_sum_o} !== 67'd0) begin
      fails++;
      $display("FAIL reset64: got valid=%b c=%b ovf=%b sum=%h, expected all zero",
               w_out_valid, w_c_o, w_ovf_o, w_sum_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, w_in_ready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_in_ready: got %b%b, expected 11", in_ready, w_in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va[6], vb[6], es[6], s;
    logic        vc[6], vs[6], ec[6], eo[6], co, ov;
    int          lat;
    va = '{32'h0000_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    vb = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'd7, 32'h0000_0001, 32'h0000_0001};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    es = '{32'h0001_0000, 32'h0, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0};
    ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    eo = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      send_recv32(va[i], vb[i], vc[i], vs[i], s, co, ov, lat);
      checks++;
      if (lat !== 2) begin
        fails++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, expected 2", i, lat);
      end
      checks++;
      if ({co, ov, s} !== {ec[i], eo[i], es[i]}) begin
        fails++;
        $display("FAIL directed[%0d]: got c=%b ovf=%b sum=%h, expected c=%b ovf=%b sum=%h",
                 i, co, ov, s, ec[i], eo[i], es[i]);
      end
    end
  endtask

  // Random stream on the 32-bit instance; rdy_pct = percentage of cycles with out_ready high.
  task automatic test_stream(input int n, input int rdy_pct, input string name);
    logic [33:0] expq[$];
    logic [65:0] r;
    logic [33:0] e;
    logic [34:0] held;
    logic        was_stall;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; was_stall = 1'b0; held = '0;
    while ((sent < n || got < n) && cyc < n * 20 + 50) begin
      @(negedge clk);
      if (was_stall) begin
        checks++;
        if ({out_valid, c_o, ovf_o, sum_o} !== held) begin
          fails++;
          $display("FAIL %s_stall_stable: got %h, expected %h", name,
                   {out_valid, c_o, ovf_o, sum_o}, held);
        end
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      in_valid  = (sent < n) && (rdy_pct == 100 || $urandom_range(1) == 1);
      a_in = $urandom; b_in = $urandom; c_in = $urandom_range(1); sub_in = $urandom_range(1);
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        fails++;
        $display("FAIL %s_in_ready: got %b, expected %b", name, in_ready,
                 !out_valid || out_ready);
      end
      if (in_valid && in_ready) begin
        r = ref_add(32, {32'd0, a_in}, {32'd0, b_in}, c_in, sub_in);
        expq.push_back({r[65:64], r[31:0]});
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL %s_extra_result: got sum=%h, expected no result", name, sum_o);
        end else begin
          e = expq.pop_front();
          if ({c_o, ovf_o, sum_o} !== e) begin
            fails++;
            $display("FAIL %s_result[%0d]: got %h, expected %h", name, got,
                     {c_o, ovf_o, sum_o}, e);
          end
        end
        got++;
      end
      was_stall = out_valid && !out_ready;
      held      = {out_valid, c_o, ovf_o, sum_o};
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== n || expq.size() != 0) begin
      fails++;
      $display("FAIL %s_count: got %0d results (%0d pending), expected %0d", name, got,
               expq.size(), n);
    end
    if (rdy_pct == 100) begin
      checks++;
      if (cyc !== n + 2) begin
        fails++;
        $display("FAIL %s_throughput: got %0d cycles, expected %0d", name, cyc, n + 2);
      end
    end
  endtask

  task automatic test_reset_midflight32();
    logic [31:0] a, b, s;
    logic        c, sb, co, ov;
    logic [65:0] r;
    int          lat;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a_in = $urandom; b_in = $urandom; c_in = 1'b0;
    sub_in = 1'b0;
    @(negedge clk);
    a_in = $urandom; b_in = $urandom;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, sum_o} !== 33'd0) begin
      fails++;
      $display("FAIL midrst32_immediate: got valid=%b sum=%h, expected 0", out_valid, sum_o);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL midrst32_stale[%0d]: got out_valid=%b, expected 0", i, out_valid);
      end
    end
    a = $urandom; b = $urandom; c = $urandom_range(1); sb = $urandom_range(1);
    r = ref_add(32, {32'd0, a}, {32'd0, b}, c, sb);
    send_recv32(a, b, c, sb, s, co, ov, lat);
    checks++;
    if (lat !== 2 || {co, ov, s} !== {r[65:64], r[31:0]}) begin
      fails++;
      $display("FAIL midrst32_next: got lat=%0d %h, expected lat=2 %h", lat, {co, ov, s},
               {r[65:64], r[31:0]});
    end
  endtask

  task automatic test_wide64();
    logic [63:0] a, b, s;
    logic        c, sb, co, ov;
    logic [65:0] r;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1; c = 1'b0; sb = 1'b0;
      end else if (i == 1) begin
        a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; c = 1'b0; sb = 1'b0;
      end else begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        c = $urandom_range(1); sb = $urandom_range(1);
      end
      r = ref_add(64, a, b, c, sb);
      send_recv64(a, b, c, sb, s, co, ov, lat);
      checks++;
      if (lat !== 4 || {co, ov, s} !== r) begin
        fails++;
        $display("FAIL wide64[%0d]: got lat=%0d %h, expected lat=4 %h", i, lat, {co, ov, s}, r);
      end
    end
  endtask

  task automatic test_reset_midflight64();
    logic [63:0] a, b, s;
    logic        co, ov;
    logic [65:0] r;
    int          lat;
    @(negedge clk);
    w_out_ready = 1'b1; w_in_valid = 1'b1; w_a_in = {$urandom, $urandom};
    w_b_in = {$urandom, $urandom}; w_c_in = 1'b0; w_sub_in = 1'b0;
    @(negedge clk);
    w_a_in = {$urandom, $urandom};
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (w_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst64_immediate: got out_valid=%b, expected 0", w_out_valid);
    end
    @(negedge clk);
    w_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (w_out_valid !== 1'b0) begin
        fails++;
        $display("FAIL midrst64_stale[%0d]: got out_valid=%b, expected 0", i, w_out_valid);
      end
    end
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    r = ref_add(64, a, b, 1'b1, 1'b1);
    send_recv64(a, b, 1'b1, 1'b1, s, co, ov, lat);
    checks++;
    if (lat !== 4 || {co, ov, s} !== r) begin
      fails++;
      $display("FAIL midrst64_next: got lat=%0d %h, expected lat=4 %h", lat, {co, ov, s}, r);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0; c_in = 1'b0; sub_in = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_a_in = '0; w_b_in = '0; w_c_in = 1'b0;
    w_sub_in = 1'b0;
    test_reset();
    test_directed();
    test_stream(100, 100, "stream");
    test_stream(100, 50, "backpressure");
    test_reset_midflight32();
    test_wide64();
    test_reset_midflight64();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
